// File: rtl/seq_pkg.sv
// Shared opcodes, T-state encoding and control-word layout for the fetch/decode/execute sequencer.
package seq_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_LDA     = 8'h01;
  localparam logic [7:0] OP_LDB     = 8'h02;
  localparam logic [7:0] OP_ADD_A   = 8'h03;
  localparam logic [7:0] OP_ADD_B   = 8'h04;
  localparam logic [7:0] OP_ADD_OUT = 8'h05;
  localparam logic [7:0] OP_SUB_A   = 8'h06;
  localparam logic [7:0] OP_SUB_B   = 8'h07;
  localparam logic [7:0] OP_SUB_OUT = 8'h08;
  localparam logic [7:0] OP_JMP     = 8'h09;
  localparam logic [7:0] OP_JZ      = 8'h0A;
  localparam logic [7:0] OP_HLT     = 8'hFF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } t_state_e;

  // Field order matches the control outputs of control_sequencer.
  typedef struct packed {
    logic pc_enable_out;
    logic pc_increment;
    logic pc_load;
    logic mar_enable_in;
    logic ram_enable_out;
    logic a_enable_in;
    logic b_enable_in;
    logic c_enable_out;
    logic out_enable_in;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational microcode: (IR, T-state, zero flag) -> control word and last-step marker.
module control_decode
  import seq_pkg::*;
#(
  parameter logic [7:0] HALT_OPCODE = OP_HLT
) (
  input  logic [7:0] ir,
  input  t_state_e   t_state,
  input  logic       zero,
  output ctrl_t      ctrl,
  output logic       last
);

  always_comb begin
    ctrl = '0;
    last = 1'b0;
    if (t_state == T0) begin
      ctrl.pc_enable_out = 1'b1;
      ctrl.mar_enable_in = 1'b1;
    end else if (t_state == T1) begin
      ctrl.ram_enable_out = 1'b1;
      ctrl.pc_increment   = 1'b1;
    end else if (ir == HALT_OPCODE) begin
      last = 1'b0;
    end else begin
      case (ir)
        OP_LDA, OP_LDB: begin
          case (t_state)
            T2: begin
              ctrl.pc_enable_out = 1'b1;
              ctrl.mar_enable_in = 1'b1;
            end
            T3: begin
              ctrl.ram_enable_out = 1'b1;
              ctrl.mar_enable_in  = 1'b1;
              ctrl.pc_increment   = 1'b1;
            end
            T4: begin
              ctrl.ram_enable_out = 1'b1;
              ctrl.a_enable_in    = (ir == OP_LDA);
              ctrl.b_enable_in    = (ir == OP_LDB);
              last                = 1'b1;
            end
            default: last = 1'b1;
          endcase
        end
        OP_ADD_A, OP_ADD_B, OP_ADD_OUT, OP_SUB_A, OP_SUB_B, OP_SUB_OUT: begin
          last = 1'b1;
          if (t_state == T2) begin
            ctrl.c_enable_out  = 1'b1;
            ctrl.a_enable_in   = (ir == OP_ADD_A)   || (ir == OP_SUB_A);
            ctrl.b_enable_in   = (ir == OP_ADD_B)   || (ir == OP_SUB_B);
            ctrl.out_enable_in = (ir == OP_ADD_OUT) || (ir == OP_SUB_OUT);
          end
        end
        OP_JMP, OP_JZ: begin
          case (t_state)
            T2: begin
              // An untaken JZ just steps the PC past its operand byte.
              if (ir == OP_JZ && !zero) begin
                ctrl.pc_increment = 1'b1;
                last              = 1'b1;
              end else begin
                ctrl.pc_enable_out = 1'b1;
                ctrl.mar_enable_in = 1'b1;
              end
            end
            T3: begin
              ctrl.ram_enable_out = 1'b1;
              ctrl.pc_load        = 1'b1;
              last                = 1'b1;
            end
            default: last = 1'b1;
          endcase
        end
        default: last = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: holds IR, T-state counter and sticky halt, gates decoded controls.
// Optional single-step mode (input step) is enabled by defining SEQ_SINGLE_STEP_EN.
//
// state | meaning
// T0    | PC drives bus, MAR loads
// T1    | RAM drives bus, IR loads, PC increments
// T2-T4 | opcode-dependent execute steps
// T5    | unused, always forced back to T0
module control_sequencer
  import seq_pkg::*;
#(
  parameter logic [7:0]  HALT_OPCODE   = OP_HLT,
  parameter int unsigned ZERO_FLAG_BIT = 0,
  parameter int unsigned MAX_STEP      = 5
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] bus,
  input  logic [3:0] flags,
  output logic       pc_enable_out,
  output logic       pc_increment,
  output logic       pc_load,
  output logic       mar_enable_in,
  output logic       ram_enable_out,
  output logic       a_enable_in,
  output logic       b_enable_in,
  output logic       c_enable_out,
  output logic       out_enable_in,
  output logic [7:0] operation,
  output logic [2:0] t_state,
  output logic       halted
);

  t_state_e   t_q, t_next;
  logic [7:0] ir_q, ir_next;
  logic       halted_q, halted_next;
  logic       run_q;
  logic       advance;
  logic       last;
  ctrl_t      dec_ctrl, ctrl;
  logic       flags_unused;

  assign flags_unused = ^flags;

`ifdef SEQ_SINGLE_STEP_EN
  logic [1:0] step_sync;
  logic       step_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_sync <= 2'b00;
      step_prev <= 1'b0;
    end else begin
      step_sync <= {step_sync[0], step};
      step_prev <= step_sync[1];
    end
  end

  assign advance = run_q & step_sync[1] & ~step_prev;
`else
  assign advance = run_q;
`endif

  // run_q holds everything idle for the first cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_q      <= T0;
      ir_q     <= OP_NOP;
      halted_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      t_q      <= t_next;
      ir_q     <= ir_next;
      halted_q <= halted_next;
      run_q    <= 1'b1;
    end
  end

  always_comb begin
    t_next      = t_q;
    ir_next     = ir_q;
    halted_next = halted_q;
    if (advance && !halted_q) begin
      if (t_q == T1) ir_next = bus;
      if (t_q == T2 && ir_q == HALT_OPCODE) halted_next = 1'b1;
      else if (last || t_q == t_state_e'(MAX_STEP[2:0])) t_next = T0;
      else t_next = t_state_e'(t_q + 3'd1);
    end
  end

  control_decode #(
    .HALT_OPCODE (HALT_OPCODE)
  ) u_decode (
    .ir      (ir_q),
    .t_state (t_q),
    .zero    (flags[ZERO_FLAG_BIT]),
    .ctrl    (dec_ctrl),
    .last    (last)
  );

  // Bus drivers follow the decode; register loads only fire on an advancing cycle.
  always_comb begin
    ctrl = dec_ctrl;
    if (!run_q || halted_q) ctrl = '0;
    if (!advance) begin
      ctrl.a_enable_in   = 1'b0;
      ctrl.b_enable_in   = 1'b0;
      ctrl.mar_enable_in = 1'b0;
      ctrl.out_enable_in = 1'b0;
      ctrl.pc_increment  = 1'b0;
      ctrl.pc_load       = 1'b0;
    end
  end

  assign pc_enable_out  = ctrl.pc_enable_out;
  assign pc_increment   = ctrl.pc_increment;
  assign pc_load        = ctrl.pc_load;
  assign mar_enable_in  = ctrl.mar_enable_in;
  assign ram_enable_out = ctrl.ram_enable_out;
  assign a_enable_in    = ctrl.a_enable_in;
  assign b_enable_in    = ctrl.b_enable_in;
  assign c_enable_out   = ctrl.c_enable_out;
  assign out_enable_in  = ctrl.out_enable_in;
  assign operation      = ir_q;
  assign t_state        = t_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: behavioural datapath around the DUT plus an instruction-level reference model.
module tb_control_sequencer;

  localparam int BUDGET = 2000;
  localparam logic [8:0] PCE = 9'h100, PCI = 9'h080, PCL = 9'h040, MAR = 9'h020, RAM = 9'h010;
  localparam logic [8:0] AEN = 9'h008, BEN = 9'h004, CEN = 9'h002, OEN = 9'h001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] bus;
  logic [3:0] flags;
  logic       pc_enable_out, pc_increment, pc_load, mar_enable_in, ram_enable_out;
  logic       a_enable_in, b_enable_in, c_enable_out, out_enable_in;
  logic [7:0] operation;
  logic [2:0] t_state;
  logic       halted;
  logic [8:0] ctrl_vec;

  int compared;
  int mismatched;

  always #5 clk = ~clk;

`ifdef SEQ_SINGLE_STEP_EN
  logic step, auto_step = 1'b1, manual_step = 1'b0;
  logic [31:0] step_cnt = 0;
  always @(posedge clk) step_cnt <= step_cnt + 1;
  assign step = auto_step ? step_cnt[1] : manual_step;
`endif

  control_sequencer dut (
    .clk            (clk),
    .reset          (reset),
`ifdef SEQ_SINGLE_STEP_EN
    .step           (step),
`endif
    .bus            (bus),
    .flags          (flags),
    .pc_enable_out  (pc_enable_out),
    .pc_increment   (pc_increment),
    .pc_load        (pc_load),
    .mar_enable_in  (mar_enable_in),
    .ram_enable_out (ram_enable_out),
    .a_enable_in    (a_enable_in),
    .b_enable_in    (b_enable_in),
    .c_enable_out   (c_enable_out),
    .out_enable_in  (out_enable_in),
    .operation      (operation),
    .t_state        (t_state),
    .halted         (halted)
  );

  assign ctrl_vec = {pc_enable_out, pc_increment, pc_load, mar_enable_in, ram_enable_out,
                     a_enable_in, b_enable_in, c_enable_out, out_enable_in};

  // Datapath around the sequencer: PC, MAR, RAM, A, B, OUT, ALU and zero flag.
  logic [7:0] mem [256];
  logic [7:0] pc, mar, reg_a, reg_b, reg_out, alu;
  logic       zf;
  logic       use_zf = 1'b1;
  logic [3:0] flags_drv = 4'b0000;

  always_comb begin
    if (operation inside {8'h03, 8'h04, 8'h05}) alu = reg_a + reg_b;
    else if (operation inside {8'h06, 8'h07, 8'h08}) alu = reg_a - reg_b;
    else alu = 8'h00;
  end

  assign bus   = pc_enable_out ? pc : ram_enable_out ? mem[mar] : c_enable_out ? alu : 8'h00;
  assign flags = use_zf ? {3'b000, zf} : flags_drv;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 8'h00; mar <= 8'h00; reg_a <= 8'h00; reg_b <= 8'h00; reg_out <= 8'h00; zf <= 1'b0;
    end else begin
      if (mar_enable_in) mar <= bus;
      if (a_enable_in) reg_a <= bus;
      if (b_enable_in) reg_b <= bus;
      if (out_enable_in) reg_out <= bus;
      if (pc_load) pc <= bus;
      else if (pc_increment) pc <= pc + 8'h01;
      if (c_enable_out) zf <= (alu == 8'h00);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    check("bus_single_driver", 32'($countones({pc_enable_out, ram_enable_out, c_enable_out}) <= 1), 32'd1);
    if (!reset) begin
      check("reset_ctrl", 32'(ctrl_vec), 32'd0);
      check("reset_op", 32'(operation), 32'd0);
    end
    if (halted) check("halted_ctrl", 32'(ctrl_vec), 32'd0);
  end

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_state(input logic [7:0] op, input logic [2:0] ts, input string tag, output bit ok);
    int n = 0;
    while (!(operation === op && t_state === ts) && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    ok = (n < BUDGET);
    if (!ok) begin
      compared++; mismatched++;
      $error("FAIL %s: op/T-state %0h/%0d never reached, required %0h/%0d", tag, operation, t_state, op, ts);
    end
  endtask

  // OR of all controls seen while in (op, ts); returns in the first cycle of the following state.
  task automatic visit(input logic [7:0] op, input logic [2:0] ts, input string tag,
                       output logic [8:0] seen, output logic [7:0] bus_seen);
    bit ok;
    int n = 0;
    seen = '0; bus_seen = '0;
    wait_state(op, ts, tag, ok);
    if (!ok) return;
    seen = ctrl_vec; bus_seen = bus;
    do begin
      @(posedge clk); #1; n++;
      if (operation === op && t_state === ts) seen |= ctrl_vec;
    end while (operation === op && t_state === ts && n < BUDGET);
  endtask

  task automatic wait_halt(input string tag, output int n);
    n = 0;
    while (!halted && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    if (!halted) begin
      compared++; mismatched++;
      $error("FAIL %s: halted=%0b after %0d cycles, required 1", tag, halted, n);
    end
  endtask

  // Instruction-level interpreter; cycles counted per instruction from the run edge to halted.
  task automatic ref_run(output logic [7:0] ea, output logic [7:0] eb, output logic [7:0] eo,
                         output logic [7:0] epc, output int ecyc);
    logic [7:0] p, op, r;
    logic z;
    int d;
    ea = 0; eb = 0; eo = 0; p = 0; z = 0; ecyc = 0;
    for (int k = 0; k < 64; k++) begin
      op = mem[p]; p = p + 8'd1;
      if (op == 8'hFF) begin ecyc += 3; break; end
      case (op)
        8'h01: begin ea = mem[mem[p]]; p = p + 8'd1; ecyc += 5; end
        8'h02: begin eb = mem[mem[p]]; p = p + 8'd1; ecyc += 5; end
        8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: begin
          r = (op <= 8'h05) ? ea + eb : ea - eb;
          z = (r == 8'h00);
          d = (op - 8'h03) % 3;
          if (d == 0) ea = r; else if (d == 1) eb = r; else eo = r;
          ecyc += 3;
        end
        8'h09: begin p = mem[p]; ecyc += 4; end
        8'h0A: begin
          if (z) begin p = mem[p]; ecyc += 4; end
          else begin p = p + 8'd1; ecyc += 3; end
        end
        default: ecyc += 3;
      endcase
    end
    epc = p;
  endtask

  // Random terminating program: jumps only target later instruction starts or the final halt.
  task automatic gen_prog(input int n);
    logic [7:0] ops [12];
    int st [13];
    int a, k;
    for (int i = 0; i < 256; i++) mem[i] = (i >= 128) ? 8'($urandom_range(0, 3)) : 8'hFF;
    a = 0;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 11);
      if (k == 11) ops[i] = 8'($urandom_range(11, 254));
      else ops[i] = 8'(k);
      st[i] = a;
      a += (ops[i] inside {8'h01, 8'h02, 8'h09, 8'h0A}) ? 2 : 1;
    end
    st[n] = a;
    for (int i = 0; i < n; i++) begin
      mem[st[i]] = ops[i];
      if (ops[i] inside {8'h01, 8'h02}) mem[st[i] + 1] = 8'($urandom_range(128, 255));
      if (ops[i] inside {8'h09, 8'h0A}) mem[st[i] + 1] = 8'(st[$urandom_range(i + 1, n)]);
    end
    mem[st[n]] = 8'hFF;
  endtask

  logic [8:0] seen;
  logic [7:0] bseen, ea, eb, eo, epc;
  int         ecyc, ncyc;
  bit         ok;

  initial begin
    compared = 0;
    mismatched = 0;
    #1;
    check("rst_ctrl", 32'(ctrl_vec), 32'd0);
    check("rst_t_state", 32'(t_state), 32'd0);
    check("rst_operation", 32'(operation), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // LDA/LDB/ADD program, interrupted by reset mid-T3 of the first LDA
    fill_mem(8'hFF);
    mem[0] = 8'h01; mem[1] = 8'h10; mem[2] = 8'h02; mem[3] = 8'h11; mem[4] = 8'h03; mem[5] = 8'hFF;
    mem[8'h10] = 8'd5; mem[8'h11] = 8'd3;
    do_reset();
    wait_state(8'h01, 3'd3, "lda_t3", ok);
    #2 reset = 1'b0;
    #1;
    check("midrst_ctrl", 32'(ctrl_vec), 32'd0);
    check("midrst_t_state", 32'(t_state), 32'd0);
    check("midrst_ir", 32'(operation), 32'd0);
    @(negedge clk) reset = 1'b1;
    #1 check("first_cycle_ctrl", 32'(ctrl_vec), 32'd0);
    @(posedge clk); #1;
    check("restart_t_state", 32'(t_state), 32'd0);
    check("restart_pc_out", 32'(pc_enable_out), 32'd1);
    check("restart_bus", 32'(bus), 32'd0);
    wait_halt("add_prog", ncyc);
    check("add_reg_a", 32'(reg_a), 32'd8);
    check("add_halted", 32'(halted), 32'd1);
    check("halt_t_state", 32'(t_state), 32'd2);
    check("halt_operation", 32'(operation), 32'hFF);
    repeat (20) begin
      @(posedge clk); #1;
      check("halt_quiet_ctrl", 32'(ctrl_vec), 32'd0);
      check("halt_quiet_t", 32'(t_state), 32'd2);
    end

    // SUB to output register
    fill_mem(8'hFF);
    mem[0] = 8'h01; mem[1] = 8'h20; mem[2] = 8'h02; mem[3] = 8'h21; mem[4] = 8'h08; mem[5] = 8'hFF;
    mem[8'h20] = 8'd9; mem[8'h21] = 8'd4;
    do_reset();
    visit(8'h08, 3'd2, "sub_out_t2", seen, bseen);
    check("sub_out_ctrl", 32'(seen), 32'(CEN | OEN));
    check("sub_out_bus", 32'(bseen), 32'd5);
    wait_halt("sub_prog", ncyc);
    check("sub_out_reg", 32'(reg_out), 32'd5);

    // JZ taken / not taken with forced flags
    use_zf = 1'b0;
    flags_drv = 4'b0001;
    fill_mem(8'hFF);
    mem[0] = 8'h0A; mem[1] = 8'h20;
    do_reset();
    visit(8'h0A, 3'd2, "jz_taken_t2", seen, bseen);
    check("jz_taken_t2_ctrl", 32'(seen), 32'(PCE | MAR));
    visit(8'h0A, 3'd3, "jz_taken_t3", seen, bseen);
    check("jz_taken_t3_ctrl", 32'(seen), 32'(RAM | PCL));
    check("jz_taken_bus", 32'(bseen), 32'h20);
    check("jz_taken_next_t", 32'(t_state), 32'd0);
    wait_halt("jz_taken", ncyc);
    check("jz_taken_pc", 32'(pc), 32'h21);

    flags_drv = 4'b0000;
    fill_mem(8'hFF);
    mem[0] = 8'h0A; mem[1] = 8'h20;
    do_reset();
    visit(8'h0A, 3'd2, "jz_not_t2", seen, bseen);
    check("jz_not_t2_ctrl", 32'(seen), 32'(PCI));
    check("jz_not_next_t", 32'(t_state), 32'd0);
    wait_halt("jz_not", ncyc);
    check("jz_not_pc", 32'(pc), 32'h03);
    use_zf = 1'b1;

    // undefined opcode
    fill_mem(8'hFF);
    mem[0] = 8'h42;
    do_reset();
    visit(8'h42, 3'd2, "undef_t2", seen, bseen);
    check("undef_t2_ctrl", 32'(seen), 32'd0);
    check("undef_next_t", 32'(t_state), 32'd0);

    // random programs against the instruction-level model
    for (int it = 0; it < 25; it++) begin
      gen_prog($urandom_range(1, 12));
      ref_run(ea, eb, eo, epc, ecyc);
      do_reset();
      @(posedge clk);
      wait_halt("rand_halt", ncyc);
      check("rand_reg_a", 32'(reg_a), 32'(ea));
      check("rand_reg_b", 32'(reg_b), 32'(eb));
      check("rand_reg_out", 32'(reg_out), 32'(eo));
      check("rand_pc", 32'(pc), 32'(epc));
`ifndef SEQ_SINGLE_STEP_EN
      check("rand_cycles", 32'(ncyc), 32'(ecyc));
`endif
    end

`ifdef SEQ_SINGLE_STEP_EN
    begin
      logic [2:0] t_hold;
      logic [2:0] t_exp [3];
      t_exp[0] = 3'd1; t_exp[1] = 3'd2; t_exp[2] = 3'd0;
      fill_mem(8'h00);
      auto_step = 1'b0;
      manual_step = 1'b0;
      do_reset();
      @(posedge clk); #1;
      t_hold = t_state;
      check("step_start_t", 32'(t_hold), 32'd0);
      repeat (10) begin
        @(posedge clk); #1;
        check("step_hold_t", 32'(t_state), 32'(t_hold));
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk) manual_step = 1'b1;
        repeat (3) @(negedge clk);
        manual_step = 1'b0;
        repeat (4) @(negedge clk);
        check("step_pulse_t", 32'(t_state), 32'(t_exp[i]));
      end
      auto_step = 1'b1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
